// File: rtl/alu_seq_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_unit_if
//  Description : Handshake bundle for alu_seq_unit. It carries the operand
//                stream (in_valid/in_ready, x, y, op) and the result stream
//                (out_valid/out_ready, result, flags, busy).
//                - master : producer/consumer side. It drives the operands
//                           and out_ready.
//                - slave  : ALU side. It drives in_ready, the result, the
//                           flags and busy.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             busy;

  modport master (
    output in_valid, x, y, op, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, busy
  );

  modport slave (
    input  in_valid, x, y, op, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_unit
//  Description : Handshaked WIDTH-bit ALU with eight operations and Z/N/C/V
//                status flags.
//                - Ops 000..110 complete one cycle after accept.
//                - Op 111 (MUL) is an iterative shift-add multiply. It
//                  completes WIDTH+1 cycles after accept.
//                The unit holds one operation at a time.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                bus   - alu_seq_unit_if.slave. Carries the operand and
//                        result handshakes, the flags and busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_unit #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_unit_if.slave bus
);

  localparam int SH_W = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;
  localparam logic [SH_W-1:0] LAST_ITER = SH_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic [WIDTH-1:0]   result_q;
  logic               flag_z_q;
  logic               flag_n_q;
  logic               flag_c_q;
  logic               flag_v_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [SH_W-1:0]    cnt_q;

  // Single-cycle datapath. It works directly on the bus operands so that the
  // result can be registered on the accept edge.
  logic [WIDTH-1:0]   alu_res_d;
  logic               alu_c_d;
  logic               alu_v_d;
  logic [WIDTH:0]     alu_ext_d;

  always_comb begin
    alu_res_d = '0;
    alu_c_d   = 1'b0;
    alu_v_d   = 1'b0;
    alu_ext_d = '0;
    case (bus.op)
      3'b000: begin
        alu_ext_d = {1'b0, bus.x} + {1'b0, bus.y};
        alu_res_d = alu_ext_d[WIDTH-1:0];
        alu_c_d   = alu_ext_d[WIDTH];
        alu_v_d   = (bus.x[MSB] == bus.y[MSB]) && (alu_res_d[MSB] != bus.x[MSB]);
      end
      3'b001: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        alu_ext_d = {1'b0, bus.x} - {1'b0, bus.y};
        alu_res_d = alu_ext_d[WIDTH-1:0];
        alu_c_d   = alu_ext_d[WIDTH];
        alu_v_d   = (bus.x[MSB] != bus.y[MSB]) && (alu_res_d[MSB] != bus.x[MSB]);
      end
      3'b010:  alu_res_d = bus.x & bus.y;
      3'b011:  alu_res_d = ~bus.x;
      3'b100:  alu_res_d = bus.x | bus.y;
      3'b101:  alu_res_d = bus.x ^ bus.y;
      3'b110:  alu_res_d = bus.x << bus.y[SH_W-1:0];
      default: alu_res_d = '0;
    endcase
  end

  // One shift-add step. The low half of acc_q starts out holding the
  // multiplier. Its LSB gates an add of the multiplicand into the high half.
  // The whole {carry, high, low} value then shifts right by one.
  logic [WIDTH:0]     mul_sum_d;
  logic [2*WIDTH-1:0] acc_d;

  always_comb begin
    mul_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_d     = {mul_sum_d, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      mcand_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (bus.op == 3'b111) begin
              state_q <= S_EXEC;
              mcand_q <= bus.x;
              acc_q   <= {{WIDTH{1'b0}}, bus.y};
              cnt_q   <= '0;
            end else begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              result_q    <= alu_res_d;
              flag_z_q    <= (alu_res_d == '0);
              flag_n_q    <= alu_res_d[MSB];
              flag_c_q    <= alu_c_d;
              flag_v_q    <= alu_v_d;
            end
          end
        end
        S_EXEC: begin
          acc_q <= acc_d;
          if (cnt_q == LAST_ITER) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            result_q    <= acc_d[WIDTH-1:0];
            flag_z_q    <= (acc_d[WIDTH-1:0] == '0);
            flag_n_q    <= acc_d[MSB];
            flag_c_q    <= |acc_d[2*WIDTH-1:WIDTH];
            flag_v_q    <= |acc_d[2*WIDTH-1:WIDTH];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          // in_ready rises only after this edge. A request that is presented
          // during the handshake cycle is therefore not taken.
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_n    = flag_n_q;
  assign bus.flag_c    = flag_c_q;
  assign bus.flag_v    = flag_v_q;

endmodule
`default_nettype wire
